branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Execute-side counterpart of the fetch-stage branch predictor. Queues each issued JAL/B-type prediction,
//  checks it against the actual outcome from EX in program order, and on mismatch issues a redirect and
//  flush. Every resolution is also sent back as a one-cycle training update for the predictor's counter.
//  Also keeps branch and mispredict counters for performance monitoring.
// PARAMETERS
//  DEPTH      4   prediction queue entries; power of two, >= 2
//  CNT_W      32  width of performance counters
// PORTS
//  clk             in   1      clock
//  rst             in   1      reset, synchronous, active-high
//  pred_valid_i    in   1      fetch pushes a prediction this cycle
//  pred_pc_i       in   32     address of the predicted control instruction
//  pred_taken_i    in   1      predicted direction
//  pred_target_i   in   32     predicted target (meaningful only if pred_taken_i)
//  full_o          out  1      queue full; fetch must stall prediction-needing instructions
//  res_valid_i     in   1      EX resolves the oldest in-flight control instruction
//  res_taken_i     in   1      actual direction
//  res_target_i    in   32     actual target address
//  redirect_o      out  1      1-cycle pulse: mispredict, fetch restarts at redirect_pc_o
//  redirect_pc_o   out  32     correct next PC
//  flush_o         out  1      1-cycle pulse, same cycle as redirect_o: kill IF/ID wrong-path work
//  upd_valid_o     out  1      training update valid (to predictor last_need_predict_i)
//  upd_taken_o     out  1      actual outcome (to predictor last_jump_i)
//  upd_pc_o        out  32     resolved instruction address (to predictor last_addr_i)
//  err_o           out  1      sticky: push on full or resolve on empty seen; cleared only by rst
//  branch_cnt_o    out  CNT_W  resolutions counted
//  mispred_cnt_o   out  CNT_W  mispredicts counted
// BEHAVIOUR
//  Reset: queue empty, rd/wr pointers 0, count 0; every output 0 (full_o=0, redirect_pc_o=0, upd_pc_o=0).
//  Queue: circular FIFO, pointers log2(DEPTH) bits wrapping naturally; count 0..DEPTH; full_o = (count==DEPTH).
//  Push accepted when pred_valid_i && !full_o, except when dropped by a flush (below).
//  Push while full: entry dropped, err_o set, pointers unchanged.
//  Resolve acts on the head entry when res_valid_i && count!=0; resolve on empty: ignored, err_o set.
//  Push and resolve in the same cycle, no mispredict: both done, count unchanged. Allowed even when full,
//   since full_o is the registered state at the start of the cycle.
//  Mispredict = (pred_taken != res_taken_i) || (res_taken_i && pred_target != res_target_i).
//   The predicted target is not compared when both directions are not-taken.
//  Correct PC = res_target_i if res_taken_i, else head.pc + 4 (32-bit wrap).
//  Latency: all outputs are registered and appear the cycle after the resolve (N+1).
//   On a mispredict in cycle N: redirect_o=flush_o=1 in cycle N+1 with redirect_pc_o = correct PC.
//   redirect_o and flush_o are asserted for exactly 1 cycle.
//  Flush: on a mispredict in cycle N, the queue is emptied at the end of cycle N (pointers and count to 0).
//   All younger entries are wrong-path. A push in cycle N is dropped, and so is a push in cycle N+1
//   (flush cycle). Pushes are accepted again from N+2.
//  Training: every valid resolve gives upd_valid_o=1 in N+1 with upd_taken_o=res_taken_i and
//   upd_pc_o=head.pc, whether or not it mispredicted. Otherwise upd_valid_o=0; upd_taken_o/upd_pc_o hold.
//  Counters: branch_cnt_o +1 per valid resolve; mispred_cnt_o +1 per mispredict; both wrap modulo 2^CNT_W.
//   They update in N+1 together with the other outputs.
//  redirect_pc_o holds its last value while redirect_o=0.
//  rst mid-operation: queue is discarded; any pending redirect/update pulse is suppressed next cycle.
//  Counters and err_o return to 0.
// TESTING
//  T1 push {0x100,T,0x80}; resolve T,0x80 -> N+1: upd_valid=1,upd_taken=1,upd_pc=0x100, redirect=0,
//     branch_cnt=1, mispred_cnt=0.
//  T2 push {0x200,NT}; resolve T,0x240 -> N+1: redirect=flush=1, redirect_pc=0x240, mispred_cnt=1.
//     Case with push {0x204,..} in N: push dropped, count=0 after.
//  T3 push {0x300,T,0x310}; resolve T,0x320 (direction right, target wrong) -> redirect_pc=0x320.
//     Push {0xFFFFFFFC,T,x}; resolve NT -> redirect_pc=0x00000000 (wrap).
//  T4 fill DEPTH=4 -> full_o=1. 5th push -> dropped, err_o=1. Then push+resolve together in one cycle
//     -> count stays 4, FIFO order preserved across pointer wrap.
//  T5 resolve with empty queue -> no upd/redirect, err_o=1. Assert rst during a pending mispredict
//     -> next cycle redirect=0, upd_valid=0, count=0, err_o=0, counters 0.
//  T6 random push/resolve stream vs reference model over 10k cycles: branch_cnt and mispred_cnt match,
//     redirect pulses never exceed 1 cycle.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Fetch/EX-facing bus of the branch resolve unit: prediction push, resolution,
// redirect/flush, predictor training and performance counters.
interface branch_resolve_if #(
  parameter int unsigned CNT_W = 32
);
  logic             pred_valid;
  logic [31:0]      pred_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             full;
  logic             res_valid;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             upd_valid;
  logic             upd_taken;
  logic [31:0]      upd_pc;
  logic             err;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_taken, res_target,
    input  full, redirect, redirect_pc, flush,
    input  upd_valid, upd_taken, upd_pc, err, branch_cnt, mispred_cnt
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_taken, res_target,
    output full, redirect, redirect_pc, flush,
    output upd_valid, upd_taken, upd_pc, err, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Queues fetch-stage branch predictions, checks them in order against EX outcomes,
// and produces redirect/flush, predictor training updates and perf counters.
module branch_resolve_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  branch_resolve_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CQ_W  = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  pred_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CQ_W-1:0]  count;

  logic             full_q;
  logic             redirect_q;
  logic [31:0]      redirect_pc_q;
  logic             upd_valid_q;
  logic             upd_taken_q;
  logic [31:0]      upd_pc_q;
  logic             err_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  pred_t            head;
  logic             do_res;
  logic             mispred;
  logic             do_pop;
  logic             do_push;
  logic             push_err;
  logic             res_err;
  logic [31:0]      correct_pc;
  logic [CQ_W-1:0]  count_nxt;

  // Resolve/push decisions for this cycle; the flush pulse (redirect_q) blocks pushes
  always_comb begin
    head       = mem[rd_ptr];
    do_res     = bus.res_valid && (count != '0);
    mispred    = do_res && ((head.taken != bus.res_taken) ||
                            (bus.res_taken && (head.target != bus.res_target)));
    do_pop     = do_res && !mispred;
    do_push    = bus.pred_valid && (!full_q || do_res) && !mispred && !redirect_q;
    push_err   = bus.pred_valid && full_q && !do_res;
    res_err    = bus.res_valid && (count == '0);
    correct_pc = bus.res_taken ? bus.res_target : head.pc + 32'd4;
    count_nxt  = count;
    if (mispred) begin
      count_nxt = '0;
    end else if (do_push && !do_pop) begin
      count_nxt = count + CQ_W'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CQ_W'(1);
    end
  end

  // Prediction storage carries no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      full_q        <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_taken_q   <= 1'b0;
      upd_pc_q      <= '0;
      err_q         <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      count      <= count_nxt;
      full_q     <= (count_nxt == CQ_W'(DEPTH));
      redirect_q <= mispred;
      err_q      <= err_q | push_err | res_err;
      if (mispred) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        redirect_pc_q <= correct_pc;
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      upd_valid_q <= do_res;
      if (do_res) begin
        upd_taken_q  <= bus.res_taken;
        upd_pc_q     <= head.pc;
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.full        = full_q;
  assign bus.redirect    = redirect_q;
  assign bus.flush       = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.upd_pc      = upd_pc_q;
  assign bus.err         = err_q;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
endmodule
